// File: rtl/eth_parser_pkg.sv
// Shared types for the Ethernet parser and the frame dispatcher that sits behind it.
// Holds the per-frame metadata layout, the egress route encoding, the dispatcher
// state encoding and a helper that turns parsed protocol flags into a route.
package eth_parser_pkg;

    typedef struct packed {
        logic [47:0] dest_mac;
        logic        vlan_present;
        logic [11:0] vlan_id;
        logic        is_ipv4;
        logic        is_ipv6;
        logic        is_arp;
        logic        is_unknown;
    } eth_metadata_t;

    typedef enum logic [1:0] {
        ROUTE_IPV4  = 2'd0,
        ROUTE_IPV6  = 2'd1,
        ROUTE_ARP   = 2'd2,
        ROUTE_OTHER = 2'd3
    } route_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_DROP = 2'd2
    } dispatch_state_t;

    localparam logic [47:0] MAC_BROADCAST = 48'hFFFF_FFFF_FFFF;

    // Protocol flags are one-hot from the parser; anything unflagged goes to the catch-all route.
    function automatic route_t routeOf(input eth_metadata_t meta);
        route_t route;
        if (meta.is_ipv4) begin
            route = ROUTE_IPV4;
        end else if (meta.is_ipv6) begin
            route = ROUTE_IPV6;
        end else if (meta.is_arp) begin
            route = ROUTE_ARP;
        end else begin
            route = ROUTE_OTHER;
        end
        return route;
    endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// Single-clock show-ahead FIFO: the head entry is always visible on o_rd_data,
// and i_rd_en consumes it. Writes into a full FIFO and reads from an empty one are ignored.
module axis_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_wr_en,
    input  logic [WIDTH-1:0]       i_wr_data,
    input  logic                   i_rd_en,
    output logic [WIDTH-1:0]       o_rd_data,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wrPtr;
    logic [AW:0]      r_rdPtr;
    logic             w_empty;
    logic             w_full;
    logic             w_write;
    logic             w_read;

    // Pointers carry one extra wrap bit so full and empty can be told apart.
    assign w_empty = (r_wrPtr == r_rdPtr);
    assign w_full  = (r_wrPtr[AW] != r_rdPtr[AW]) && (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
    assign w_write = i_wr_en & ~w_full;
    assign w_read  = i_rd_en & ~w_empty;

    assign o_rd_data = r_mem[r_rdPtr[AW-1:0]];
    assign o_empty   = w_empty;
    assign o_count   = r_wrPtr - r_rdPtr;

    // Storage array; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (w_write) begin
            r_mem[r_wrPtr[AW-1:0]] <= i_wr_data;
        end
    end

    // Pointer advance on accepted writes and reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            if (w_write) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_read) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/eth_frame_dispatcher.sv
// Ethernet frame dispatcher: buffers parser beats, pairs each frame with its metadata
// in arrival order, filters on destination MAC and forwards accepted frames with a
// protocol route on m_axis_tdest. Rejected frames are drained silently.
// Optional VLAN filter: define ETH_DISPATCH_VLAN_FILTER_EN to add cfg_vlan_en/cfg_vlan_id.
module eth_frame_dispatcher
    import eth_parser_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int FIFO_DEPTH = 64,
    parameter int META_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [DATA_WIDTH-1:0]              s_axis_tdata,
    input  logic                               s_axis_tvalid,
    output logic                               s_axis_tready,
    input  logic                               s_axis_tlast,
    input  logic [$bits(eth_metadata_t)-1:0]   s_axis_tuser,
    input  logic                               s_axis_tuser_valid,
    output logic [DATA_WIDTH-1:0]              m_axis_tdata,
    output logic                               m_axis_tvalid,
    input  logic                               m_axis_tready,
    output logic                               m_axis_tlast,
    output logic [1:0]                         m_axis_tdest,
    input  logic [47:0]                        cfg_local_mac,
    input  logic                               cfg_promisc,
`ifdef ETH_DISPATCH_VLAN_FILTER_EN
    input  logic                               cfg_vlan_en,
    input  logic [11:0]                        cfg_vlan_id,
`endif
    output logic [31:0]                        fwd_count,
    output logic [31:0]                        drop_count,
    output logic                               err_meta
);

    localparam int MW  = $bits(eth_metadata_t);
    localparam int CW  = $clog2(META_DEPTH) + 1;
    localparam int FCW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0]    META_LIMIT = (CW + 1)'(META_DEPTH);
    localparam logic [FCW-1:0] DATA_LIMIT = FCW'(FIFO_DEPTH);
    localparam logic [31:0]    COUNT_MAX  = 32'hFFFF_FFFF;

    logic                  r_readyEn;
    logic                  r_inFrame;
    logic                  r_errMeta;
    logic [CW-1:0]         r_pending;
    dispatch_state_t       r_state;
    route_t                r_tdest;
    logic [31:0]           r_fwdCount;
    logic [31:0]           r_dropCount;

    logic                  w_beatAccept;
    logic                  w_firstBeat;
    logic [CW-1:0]         w_pendingEff;
    logic                  w_metaAccept;
    logic                  w_metaRoom;
    logic [CW-1:0]         w_metaCount;
    logic                  w_metaEmpty;
    logic [MW-1:0]         w_metaHeadRaw;
    eth_metadata_t         w_metaHead;
    logic                  w_metaPop;
    logic [FCW-1:0]        w_dataCount;
    logic                  w_dataFull;
    logic                  w_dataEmpty;
    logic [DATA_WIDTH:0]   w_dataHead;
    logic                  w_headLast;
    logic                  w_dataPop;
    logic                  w_fwdValid;
    logic                  w_macOk;
    logic                  w_vlanOk;
    logic                  w_accept;
    logic                  w_unusedMeta;

    // Ingress admission: a new frame may only start while every queued or still-unpaired
    // frame has a guaranteed metadata slot, so the metadata queue can never overflow.
    assign w_dataFull    = (w_dataCount == DATA_LIMIT);
    assign w_metaRoom    = (({1'b0, w_metaCount} + {1'b0, r_pending}) < META_LIMIT);
    assign s_axis_tready = r_readyEn & ~w_dataFull & (r_inFrame | w_metaRoom);
    assign w_beatAccept  = s_axis_tvalid & s_axis_tready;
    assign w_firstBeat   = w_beatAccept & ~r_inFrame;

    // A first beat in the same cycle as a strobe counts first, so the strobe can pair with it.
    assign w_pendingEff = r_pending + {{(CW - 1){1'b0}}, w_firstBeat};
    assign w_metaAccept = s_axis_tuser_valid & (w_pendingEff != '0);

    // Egress handshakes; DROP ignores downstream ready and never raises valid.
    assign w_headLast = w_dataHead[DATA_WIDTH];
    assign w_fwdValid = (r_state == ST_FWD) & ~w_dataEmpty;
    assign w_dataPop  = (w_fwdValid & m_axis_tready) | ((r_state == ST_DROP) & ~w_dataEmpty);
    assign w_metaPop  = (r_state == ST_IDLE) & ~w_metaEmpty;

    assign m_axis_tvalid = w_fwdValid;
    assign m_axis_tdata  = w_fwdValid ? w_dataHead[DATA_WIDTH-1:0] : '0;
    assign m_axis_tlast  = w_fwdValid & w_headLast;
    assign m_axis_tdest  = r_tdest;
    assign fwd_count     = r_fwdCount;
    assign drop_count    = r_dropCount;
    assign err_meta      = r_errMeta;

    // Destination filter: promiscuous, broadcast, any group address, or our own station.
    assign w_metaHead = eth_metadata_t'(w_metaHeadRaw);
    assign w_macOk    = cfg_promisc
                      | (w_metaHead.dest_mac == MAC_BROADCAST)
                      | w_metaHead.dest_mac[40]
                      | (w_metaHead.dest_mac == cfg_local_mac);
`ifdef ETH_DISPATCH_VLAN_FILTER_EN
    assign w_vlanOk = ~cfg_vlan_en
                    | (w_metaHead.vlan_present & (w_metaHead.vlan_id == cfg_vlan_id));
`else
    assign w_vlanOk = 1'b1;
`endif
    assign w_accept     = w_macOk & w_vlanOk;
    assign w_unusedMeta = ^{w_metaHead.is_unknown, w_metaHead.vlan_present, w_metaHead.vlan_id};

    axis_sync_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_dataFifo (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_beatAccept),
        .i_wr_data ({s_axis_tlast, s_axis_tdata}),
        .i_rd_en   (w_dataPop),
        .o_rd_data (w_dataHead),
        .o_empty   (w_dataEmpty),
        .o_count   (w_dataCount)
    );

    axis_sync_fifo #(
        .WIDTH (MW),
        .DEPTH (META_DEPTH)
    ) u_metaFifo (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_metaAccept),
        .i_wr_data (s_axis_tuser),
        .i_rd_en   (w_metaPop),
        .o_rd_data (w_metaHeadRaw),
        .o_empty   (w_metaEmpty),
        .o_count   (w_metaCount)
    );

    // Ingress bookkeeping: frame-open flag, frames awaiting metadata, sticky orphan-strobe error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_readyEn <= 1'b0;
            r_inFrame <= 1'b0;
            r_pending <= '0;
            r_errMeta <= 1'b0;
        end else begin
            r_readyEn <= 1'b1;
            if (w_beatAccept) begin
                r_inFrame <= ~s_axis_tlast;
            end
            r_pending <= w_pendingEff - {{(CW - 1){1'b0}}, w_metaAccept};
            if (s_axis_tuser_valid && (w_pendingEff == '0)) begin
                r_errMeta <= 1'b1;
            end
        end
    end

    // Egress FSM: decide per frame in IDLE, then stream it out (FWD) or discard it (DROP).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_tdest     <= ROUTE_IPV4;
            r_fwdCount  <= '0;
            r_dropCount <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_metaEmpty) begin
                        if (w_accept) begin
                            r_tdest <= routeOf(w_metaHead);
                            if (r_fwdCount != COUNT_MAX) begin
                                r_fwdCount <= r_fwdCount + 32'd1;
                            end
                            r_state <= ST_FWD;
                        end else begin
                            if (r_dropCount != COUNT_MAX) begin
                                r_dropCount <= r_dropCount + 32'd1;
                            end
                            r_state <= ST_DROP;
                        end
                    end
                end
                ST_FWD: begin
                    if (w_fwdValid && m_axis_tready && w_headLast) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_DROP: begin
                    if (!w_dataEmpty && w_headLast) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eth_frame_dispatcher.sv
// Directed testbench for eth_frame_dispatcher: filtering, routing, ordering,
// metadata backpressure, orphan metadata and asynchronous reset mid-frame.
module tb_eth_frame_dispatcher;
    import eth_parser_pkg::*;

    localparam logic [47:0] LOCAL_MAC = 48'h02_00_00_00_00_01;

    logic                             clk = 1'b0;
    logic                             rst;
    logic [63:0]                      s_axis_tdata;
    logic                             s_axis_tvalid;
    logic                             s_axis_tready;
    logic                             s_axis_tlast;
    logic [$bits(eth_metadata_t)-1:0] s_axis_tuser;
    logic                             s_axis_tuser_valid;
    logic [63:0]                      m_axis_tdata;
    logic                             m_axis_tvalid;
    logic                             m_axis_tready;
    logic                             m_axis_tlast;
    logic [1:0]                       m_axis_tdest;
    logic [47:0]                      cfg_local_mac;
    logic                             cfg_promisc;
    logic [31:0]                      fwd_count;
    logic [31:0]                      drop_count;
    logic                             err_meta;

    int checks = 0;
    int errors = 0;
    int cycleCnt = 0;
    int strobeCycle = 0;
    int validSeen = 0;

    logic [63:0] outData[$];
    logic        outLast[$];
    logic [1:0]  outDest[$];
    int          outCycle[$];

    eth_frame_dispatcher #(
        .DATA_WIDTH (64),
        .FIFO_DEPTH (64),
        .META_DEPTH (4)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .s_axis_tdata       (s_axis_tdata),
        .s_axis_tvalid      (s_axis_tvalid),
        .s_axis_tready      (s_axis_tready),
        .s_axis_tlast       (s_axis_tlast),
        .s_axis_tuser       (s_axis_tuser),
        .s_axis_tuser_valid (s_axis_tuser_valid),
        .m_axis_tdata       (m_axis_tdata),
        .m_axis_tvalid      (m_axis_tvalid),
        .m_axis_tready      (m_axis_tready),
        .m_axis_tlast       (m_axis_tlast),
        .m_axis_tdest       (m_axis_tdest),
        .cfg_local_mac      (cfg_local_mac),
        .cfg_promisc        (cfg_promisc),
`ifdef ETH_DISPATCH_VLAN_FILTER_EN
        .cfg_vlan_en        (1'b0),
        .cfg_vlan_id        (12'd0),
`endif
        .fwd_count          (fwd_count),
        .drop_count         (drop_count),
        .err_meta           (err_meta)
    );

    // Free-running clock and cycle index used for latency measurement.
    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    // Output monitor: mid-cycle, record every beat that will transfer on the coming edge.
    always @(negedge clk) begin
        if (m_axis_tvalid) validSeen <= validSeen + 1;
        if (m_axis_tvalid && m_axis_tready) begin
            outData.push_back(m_axis_tdata);
            outLast.push_back(m_axis_tlast);
            outDest.push_back(m_axis_tdest);
            outCycle.push_back(cycleCnt);
        end
    end

    // Hard stop in case something wedges the stimulus loops.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic eth_metadata_t makeMeta(input logic [47:0] mac, input int kind);
        eth_metadata_t m;
        m = '0;
        m.dest_mac   = mac;
        m.is_ipv4    = (kind == 0);
        m.is_ipv6    = (kind == 1);
        m.is_arp     = (kind == 2);
        m.is_unknown = (kind == 3);
        return m;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Sends one frame of nBeats, strobing meta together with beat metaBeat (-1: no strobe).
    task automatic applyStimulus(input int nBeats, input logic [63:0] base,
                                 input eth_metadata_t meta, input int metaBeat);
        int budget;
        for (int i = 0; i < nBeats; i++) begin
            budget = 0;
            while (!s_axis_tready && budget < 500) begin
                @(posedge clk);
                #1;
                budget++;
            end
            if (!s_axis_tready) checkOutput("ingressReadyTimeout", s_axis_tready, 1);
            s_axis_tdata       = base + 64'(i);
            s_axis_tlast       = (i == nBeats - 1);
            s_axis_tvalid      = 1'b1;
            s_axis_tuser       = meta;
            s_axis_tuser_valid = (i == metaBeat);
            if (i == metaBeat) strobeCycle = cycleCnt;
            @(posedge clk);
            #1;
            s_axis_tvalid      = 1'b0;
            s_axis_tlast       = 1'b0;
            s_axis_tuser_valid = 1'b0;
        end
    endtask

    task automatic strobeMeta(input eth_metadata_t meta);
        s_axis_tuser       = meta;
        s_axis_tuser_valid = 1'b1;
        strobeCycle        = cycleCnt;
        @(posedge clk);
        #1;
        s_axis_tuser_valid = 1'b0;
    endtask

    task automatic checkFrame(input string tag, input int startIdx, input int nBeats,
                              input logic [63:0] base, input logic [1:0] dest);
        for (int i = 0; i < nBeats; i++) begin
            if (startIdx + i < outData.size()) begin
                checkOutput($sformatf("%s_data%0d", tag, i), outData[startIdx + i], base + 64'(i));
                checkOutput($sformatf("%s_last%0d", tag, i), 64'(outLast[startIdx + i]), 64'(i == nBeats - 1));
                checkOutput($sformatf("%s_dest%0d", tag, i), 64'(outDest[startIdx + i]), 64'(dest));
            end
        end
    endtask

    initial begin
        int s;
        int vs;
        eth_metadata_t mIpv4Local;
        eth_metadata_t mForeign;
        eth_metadata_t mArpBcast;
        eth_metadata_t mIpv6Mcast;

        mIpv4Local = makeMeta(LOCAL_MAC, 0);
        mForeign   = makeMeta(48'h02_00_00_00_00_99, 0);
        mArpBcast  = makeMeta(48'hFF_FF_FF_FF_FF_FF, 2);
        mIpv6Mcast = makeMeta(48'h33_33_00_00_00_01, 1);

        rst                = 1'b1;
        s_axis_tdata       = '0;
        s_axis_tvalid      = 1'b0;
        s_axis_tlast       = 1'b0;
        s_axis_tuser       = '0;
        s_axis_tuser_valid = 1'b0;
        m_axis_tready      = 1'b1;
        cfg_local_mac      = LOCAL_MAC;
        cfg_promisc        = 1'b0;

        // Reset state
        waitCycles(2);
        checkOutput("rstTvalid", m_axis_tvalid, 0);
        checkOutput("rstTlast", m_axis_tlast, 0);
        checkOutput("rstTdest", m_axis_tdest, 0);
        checkOutput("rstSready", s_axis_tready, 0);
        checkOutput("rstFwd", fwd_count, 0);
        checkOutput("rstDrop", drop_count, 0);
        checkOutput("rstErr", err_meta, 0);
        rst = 1'b0;
        #1;
        checkOutput("releaseSreadyLow", s_axis_tready, 0);
        waitCycles(1);
        checkOutput("releaseSreadyHigh", s_axis_tready, 1);

        // 1: local unicast IPv4, metadata with the first beat
        s = outData.size();
        applyStimulus(3, 64'h1000, mIpv4Local, 0);
        waitCycles(10);
        checkOutput("t1Beats", outData.size() - s, 3);
        checkFrame("t1", s, 3, 64'h1000, 2'd0);
        if (outData.size() > s) checkOutput("t1Latency", outCycle[s] - strobeCycle, 2);
        checkOutput("t1Fwd", fwd_count, 1);
        checkOutput("t1Drop", drop_count, 0);

        // 2: foreign unicast dropped, then accepted under promiscuous mode
        s  = outData.size();
        vs = validSeen;
        applyStimulus(3, 64'h2000, mForeign, 0);
        waitCycles(10);
        checkOutput("t2NoValid", validSeen - vs, 0);
        checkOutput("t2Drop", drop_count, 1);
        checkOutput("t2FwdSame", fwd_count, 1);
        cfg_promisc = 1'b1;
        s = outData.size();
        applyStimulus(2, 64'h2100, mForeign, 1);
        waitCycles(10);
        checkOutput("t2PromBeats", outData.size() - s, 2);
        checkFrame("t2Prom", s, 2, 64'h2100, 2'd0);
        checkOutput("t2PromFwd", fwd_count, 2);
        cfg_promisc = 1'b0;

        // 3: broadcast ARP (metadata after its tlast) back-to-back with IPv6 multicast
        s = outData.size();
        applyStimulus(2, 64'h3000, mArpBcast, -1);
        applyStimulus(2, 64'h3100, mArpBcast, 0);
        strobeMeta(mIpv6Mcast);
        waitCycles(12);
        checkOutput("t3Beats", outData.size() - s, 4);
        checkFrame("t3Arp", s, 2, 64'h3000, 2'd2);
        checkFrame("t3Ipv6", s + 2, 2, 64'h3100, 2'd1);
        checkOutput("t3Fwd", fwd_count, 4);
        checkOutput("t3Err", err_meta, 0);

        // 4: downstream stalled; the first frame is held by the egress FSM and four
        //    more fill the metadata queue, after which ingress must stall
        m_axis_tready = 1'b0;
        s = outData.size();
        applyStimulus(1, 64'h4000, makeMeta(LOCAL_MAC, 0), 0);
        applyStimulus(1, 64'h4010, makeMeta(LOCAL_MAC, 1), 0);
        applyStimulus(1, 64'h4020, makeMeta(LOCAL_MAC, 2), 0);
        applyStimulus(1, 64'h4030, makeMeta(LOCAL_MAC, 3), 0);
        applyStimulus(1, 64'h4040, makeMeta(LOCAL_MAC, 0), 0);
        checkOutput("t4SreadyLow", s_axis_tready, 0);
        checkOutput("t4HoldValid", m_axis_tvalid, 1);
        waitCycles(5);
        checkOutput("t4SreadyStillLow", s_axis_tready, 0);
        checkOutput("t4NoTransfer", outData.size() - s, 0);
        m_axis_tready = 1'b1;
        applyStimulus(1, 64'h4050, makeMeta(LOCAL_MAC, 1), 0);
        waitCycles(20);
        checkOutput("t4Beats", outData.size() - s, 6);
        checkFrame("t4f0", s + 0, 1, 64'h4000, 2'd0);
        checkFrame("t4f1", s + 1, 1, 64'h4010, 2'd1);
        checkFrame("t4f2", s + 2, 1, 64'h4020, 2'd2);
        checkFrame("t4f3", s + 3, 1, 64'h4030, 2'd3);
        checkFrame("t4f4", s + 4, 1, 64'h4040, 2'd0);
        checkFrame("t4f5", s + 5, 1, 64'h4050, 2'd1);
        checkOutput("t4Fwd", fwd_count, 10);

        // 5: metadata strobe with no frame waiting for it
        strobeMeta(mIpv4Local);
        waitCycles(5);
        checkOutput("t5Err", err_meta, 1);
        checkOutput("t5Fwd", fwd_count, 10);
        checkOutput("t5Drop", drop_count, 1);

        // 6: asynchronous reset while a frame is being forwarded
        m_axis_tready = 1'b0;
        applyStimulus(2, 64'h6000, makeMeta(LOCAL_MAC, 1), 0);
        waitCycles(3);
        checkOutput("t6PreValid", m_axis_tvalid, 1);
        checkOutput("t6PreDest", m_axis_tdest, 1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("t6RstValid", m_axis_tvalid, 0);
        checkOutput("t6RstLast", m_axis_tlast, 0);
        checkOutput("t6RstDest", m_axis_tdest, 0);
        checkOutput("t6RstSready", s_axis_tready, 0);
        checkOutput("t6RstFwd", fwd_count, 0);
        checkOutput("t6RstDrop", drop_count, 0);
        checkOutput("t6RstErr", err_meta, 0);
        waitCycles(1);
        rst = 1'b0;
        m_axis_tready = 1'b1;
        waitCycles(1);
        s = outData.size();
        applyStimulus(2, 64'h6100, mArpBcast, 0);
        waitCycles(10);
        checkOutput("t6Beats", outData.size() - s, 2);
        checkFrame("t6", s, 2, 64'h6100, 2'd2);
        checkOutput("t6Fwd", fwd_count, 1);
        checkOutput("t6Drop", drop_count, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
